insmem_sync: RTL and testbench

INSMEM_SYNC -- requirements
Module: insmem_sync

---
 rtl/insmem_sync.sv | 127 ++++++++++++
 tb/tb_insmem_sync.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/insmem_sync.sv
// Instruction memory with a clear/boot phase after reset, 1-cycle fetch port and a program-load write port.
// Define INSMEM_BOOT_EN to preload a four-word boot stub at indices 0..3 during the clear phase.
module insmem_sync #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic              valid,
  output logic [DATA_W-1:0] instr,
  output logic              fault,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ack,
  output logic              rdy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_CLR, ST_RUN} state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  cnt_q;
  logic              valid_q;
  logic              fault_q;
  logic              ld_ack_q;
  logic              rdy_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              fetch_in_range;
  logic              ld_in_range;
  logic              wr_en_d;
  logic [IDX_W-1:0]  wr_idx_d;
  logic [DATA_W-1:0] wr_data_d;
  logic [DATA_W-1:0] init_word;

  // Full-width compare so that any set upper address bit faults instead of aliasing.
  assign fetch_in_range = {1'b0, addr} < DEPTH_EXT;
  assign ld_in_range    = {1'b0, ld_addr} < DEPTH_EXT;

`ifdef INSMEM_BOOT_EN
  logic [31:0] boot_word;

  always_comb begin
    boot_word = 32'h0;
    if ((cnt_q >> 2) == '0) begin
      case (cnt_q[1:0])
        2'd0:    boot_word = 32'h2010_0008;
        2'd1:    boot_word = 32'h2011_0008;
        2'd2:    boot_word = 32'h0211_9020;
        default: boot_word = 32'h1240_FFFC;
      endcase
    end
  end

  assign init_word = DATA_W'(boot_word);
`else
  assign init_word = '0;
`endif

  // Single write port shared between the clear sweep and the load port.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_idx_d  = cnt_q;
    wr_data_d = init_word;
    if (state_q == ST_CLR) begin
      wr_en_d = 1'b1;
    end else begin
      wr_en_d   = ld_we && ld_in_range;
      wr_idx_d  = ld_addr[IDX_W-1:0];
      wr_data_d = ld_data;
    end
  end

  // Plain RAM: the non-blocking read returns the pre-write word on a same-index collision.
  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      mem[wr_idx_d] <= wr_data_d;
    end
    rd_data_q <= mem[addr[IDX_W-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_CLR;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      ld_ack_q <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_CLR: begin
          valid_q  <= 1'b0;
          fault_q  <= 1'b0;
          ld_ack_q <= 1'b0;
          cnt_q    <= cnt_q + IDX_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_q <= ST_RUN;
            rdy_q   <= 1'b1;
            cnt_q   <= '0;
          end
        end
        default: begin
          valid_q  <= req;
          fault_q  <= req && !fetch_in_range;
          ld_ack_q <= ld_we && ld_in_range;
        end
      endcase
    end
  end

  // The RAM read register carries no reset; gating keeps instr at 0 when idle, faulted or in reset.
  assign instr  = (valid_q && !fault_q) ? rd_data_q : '0;
  assign valid  = valid_q;
  assign fault  = fault_q;
  assign ld_ack = ld_ack_q;
  assign rdy    = rdy_q;

endmodule

// File: tb/tb_insmem_sync.sv
// Scoreboard bench for insmem_sync: randomized fetch/load traffic against an array reference model.
// Build with INSMEM_BOOT_EN defined to check the boot-stub variant.
module tb_insmem_sync;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst_n;
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              valid;
  logic [DATA_W-1:0] instr;
  logic              fault;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ack;
  logic              rdy;

  insmem_sync #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .addr(addr), .valid(valid), .instr(instr), .fault(fault),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .rdy(rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] instr;
    logic        fault;
  } fetch_t;

  typedef struct {
    logic ack;
    logic rdy;
  } cyc_t;

  fetch_t      fetch_q[$];
  cyc_t        cyc_q[$];
  logic [31:0] model [DEPTH];
  int unsigned k;
  int          total;
  int          bad;
  bit          mon_en;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] boot_word(input int i);
`ifdef INSMEM_BOOT_EN
    case (i)
      0:       return 32'h2010_0008;
      1:       return 32'h2011_0008;
      2:       return 32'h0211_9020;
      3:       return 32'h1240_FFFC;
      default: return 32'h0;
    endcase
`else
    return 32'h0 & 32'(i);
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = boot_word(i);
  endtask

  // Called at negedge+1; drives one cycle and records what the next edge must produce.
  task automatic drive(input logic r, input logic [31:0] a, input logic w,
                       input logic [31:0] la, input logic [31:0] ld);
    fetch_t f;
    cyc_t   c;
    bit     run;
    run     = (k >= DEPTH);
    req     = r;
    addr    = a;
    ld_we   = w;
    ld_addr = la;
    ld_data = ld;
    if (run && r) begin
      f.a = a;
      if (a < DEPTH) begin
        f.instr = model[int'(a)];
        f.fault = 1'b0;
      end else begin
        f.instr = 32'h0;
        f.fault = 1'b1;
      end
      fetch_q.push_back(f);
    end
    c.ack = run && w && (la < DEPTH);
    if (c.ack) begin
      model[int'(la)] = ld;
      $display("load  addr=%h data=%h", la, ld);
    end
    c.rdy = ((k + 1) >= DEPTH);
    cyc_q.push_back(c);
    k++;
    @(negedge clk);
    #1;
  endtask

  task automatic rand_cycle();
    logic [31:0] a;
    logic [31:0] la;
    a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
    la = ($urandom_range(0, 3) == 0) ? a :
         (($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1)));
    drive($urandom_range(0, 3) != 0, a, 1'($urandom_range(0, 1)), la, $urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 1'b0;
    ld_we = 1'b0;
    #1;
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_ld_ack", 32'(ld_ack), 32'h0);
    chk("rst_rdy", 32'(rdy), 32'h0);
    fetch_q.delete();
    cyc_q.delete();
    repeat (2) @(negedge clk);
    #1;
    model_clear();
    k      = 0;
    mon_en = 1'b1;
    rst_n  = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (cyc_q.size() > 0) begin
        cyc_t c;
        c = cyc_q.pop_front();
        chk("ld_ack", 32'(ld_ack), 32'(c.ack));
        chk("rdy", 32'(rdy), 32'(c.rdy));
      end
      if (valid === 1'b1) begin
        if (fetch_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid actual=1 required=0 t=%0t", $time);
        end else begin
          fetch_t f;
          f = fetch_q.pop_front();
          $display("fetch addr=%h instr=%h fault=%0b", f.a, instr, fault);
          chk("fetch_instr", instr, f.instr);
          chk("fetch_fault", 32'(fault), 32'(f.fault));
        end
      end else begin
        chk("idle_valid", 32'(valid), 32'h0);
        chk("idle_instr", instr, 32'h0);
        chk("idle_fault", 32'(fault), 32'h0);
      end
    end
  end

  initial begin
    total   = 0;
    bad     = 0;
    k       = 0;
    mon_en  = 1'b0;
    rst_n   = 1'b1;
    req     = 1'b0;
    addr    = '0;
    ld_we   = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    @(negedge clk);
    #1;
    do_reset();

    // Traffic during the clear phase must be ignored.
    repeat (DEPTH) drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                         32'($urandom_range(0, DEPTH - 1)), $urandom);

    for (int i = 0; i < 4; i++) drive(1'b1, 32'(i), 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'h0000_0100, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'h5, 1'b1, 32'h5, 32'hDEAD_BEEF);
    drive(1'b1, 32'h5, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 32'h300, 32'h1234_5678);
    drive(1'b1, 32'h300, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    repeat (300) rand_cycle();

    drive(1'b0, 32'h0, 1'b1, 32'h5, 32'hCAFE_F00D);
    drive(1'b1, 32'h5, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'h7, 1'b1, 32'h9, 32'h0BAD_0BAD);
    do_reset();

    repeat (DEPTH) drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'h5, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'h9, 1'b0, 32'h0, 32'h0);
    repeat (60) rand_cycle();
    repeat (3) drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    chk("pending_fetches", 32'(fetch_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
